flags_context_register: RTL and testbench
=========================================

FLAGS_CONTEXT_REGISTER -- requirements
Module: flags_context_register

Interface
REQ-001 Parameter WIDTH, default 4: number of flag bits.
REQ-002 Parameter DEPTH, default 4: number of save-stack entries, legal range 1..16.
REQ-003 Parameter STICKY_MASK, WIDTH bits, default all zeros: 1 marks a sticky flag bit.
REQ-004 clk  input  1  clock; all state SHALL update on its rising edge.
REQ-005 rst  input  1  reset; asynchronous and active-high.
REQ-006 write_enable  input  1  flag write strobe.
REQ-007 wmask  input  WIDTH  per-bit write mask; only bits with wmask=1 are written.
REQ-008 d  input  WIDTH  new flag values.
REQ-009 push  input  1  save the current q onto the stack.
REQ-010 pop  input  1  restore q from the top of the stack.
REQ-011 clear_sticky  input  1  clears the sticky flag bits and err.
REQ-012 q  output  WIDTH  current flags, registered.
REQ-013 level  output  clog2(DEPTH+1)  number of valid stack entries.
REQ-014 full  output  1  level==DEPTH; empty  output  1  level==0.
REQ-015 err  output  1  sticky stack-error indicator.

Function
REQ-016 Write SHALL take effect at the next rising edge: q[i] <= d[i] where write_enable&wmask[i], else q[i] holds; latency 1 cycle.
REQ-017 Push (push=1, pop=0, not full): stack[level] <= pre-edge q; level <= level+1.
REQ-018 Push and write in the same cycle: the pushed value is the pre-write q; the write is still applied to q.
REQ-019 Pop (pop=1, push=0, not empty): q <= stack[level-1]; level <= level-1; a same-cycle write is discarded (pop wins).
REQ-020 Push when full: stack and level unchanged; err <= 1; a same-cycle write is still applied.
REQ-021 Pop when empty: q and level unchanged by pop; err <= 1; a same-cycle write is applied.
REQ-022 push and pop both asserted: no stack operation; level unchanged; err <= 1; a same-cycle write is applied.
REQ-023 full, empty and level SHALL be registered and consistent with each other in every cycle.
REQ-024 err SHALL remain set until clear_sticky or rst; if clear_sticky and a new error coincide, err SHALL be 1.
REQ-025 Stack entries beyond level are don't-care and SHALL never be driven onto q.

Reset
REQ-026 rst=1 SHALL immediately, without a clock, set q=0, level=0, empty=1, full=0 and err=0.
REQ-027 A reset during any operation SHALL discard all stack contents; operation resumes on the first rising edge after rst deasserts.

Configuration
REQ-028 Macro FLAGS_STICKY_EN defined: a bit i with STICKY_MASK[i]=1 SHALL update on write as q[i] <= q[i] | d[i] (it can only be set).
REQ-029 With FLAGS_STICKY_EN defined, clear_sticky SHALL zero the sticky bits before the same-cycle OR, so a simultaneous write of 1 leaves the bit at 1; pop still restores the bit exactly.
REQ-030 FLAGS_STICKY_EN undefined: STICKY_MASK is ignored; all bits behave as in REQ-016; clear_sticky clears only err.

Verification
REQ-031 WIDTH=4: rst, then write d=0100 with wmask=1111, then d=0011 with wmask=0001 -> q=0000, then 0100, then 0101.
REQ-032 DEPTH=2: q=0101, push; write 1010; push; write 1111; pop; pop -> q=1010, then q=0101; level sequence 1,2,1,0; full=1 only at level 2.
REQ-033 DEPTH=2 full: push -> err=1 and level stays 2; pop when empty -> err stays 1 and q unchanged; clear_sticky -> err=0.
REQ-034 push and pop together with a write of d=0011 -> level unchanged, err=1, q=0011; pop together with a write -> q equals the restored value.
REQ-035 FLAGS_STICKY_EN defined, STICKY_MASK=1000: write 1000, then write 0000 -> q[3]=1; clear_sticky -> q[3]=0; undefined -> q[3]=0 after the second write.
REQ-036 Assert rst asynchronously in the middle of a cycle with level=2, err=1 -> q, level and err are zero before the next edge; empty=1.

Source files
------------

// File: rtl/flags_context_register_if.sv
// Flag-register bus: write/mask/data and push/pop/clear strobes in; flags, stack level and status out.
// master drives the strobes and the slave returns registered state; there is no backpressure.
interface flags_context_register_if #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 4
);
    localparam int LEVEL_W = $clog2(DEPTH + 1);

    logic               write_enable;
    logic [WIDTH-1:0]   wmask;
    logic [WIDTH-1:0]   d;
    logic               push;
    logic               pop;
    logic               clear_sticky;
    logic [WIDTH-1:0]   q;
    logic [LEVEL_W-1:0] level;
    logic               full;
    logic               empty;
    logic               err;

    modport master (
        output write_enable, wmask, d, push, pop, clear_sticky,
        input  q, level, full, empty, err
    );

    modport slave (
        input  write_enable, wmask, d, push, pop, clear_sticky,
        output q, level, full, empty, err
    );
endinterface

// File: rtl/flags_context_register.sv
// Flag register with a save/restore stack; every output is registered and updates one edge after its strobe.
// Strobes are accepted every cycle (no backpressure); FLAGS_STICKY_EN makes STICKY_MASK bits set-only on write.
module flags_context_register #(
    parameter int               WIDTH       = 4,
    parameter int               DEPTH       = 4,
    parameter logic [WIDTH-1:0] STICKY_MASK = '0
) (
    input  logic                      clk,
    input  logic                      rst,
    flags_context_register_if.slave   bus
);
    localparam int LEVEL_W = $clog2(DEPTH + 1);
    localparam int IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;

`ifdef FLAGS_STICKY_EN
    localparam logic [WIDTH-1:0] STICKY_BITS = STICKY_MASK;
`else
    // The mask has no effect unless the sticky feature is compiled in.
    localparam logic [WIDTH-1:0] STICKY_BITS = STICKY_MASK & {WIDTH{1'b0}};
`endif

    logic [WIDTH-1:0]   q_r;
    logic [LEVEL_W-1:0] level_r;
    logic               full_r;
    logic               empty_r;
    logic               err_r;
    logic [WIDTH-1:0]   stack [DEPTH];

    logic               push_op;
    logic               pop_op;
    logic               do_push;
    logic               do_pop;
    logic               stack_err;
    logic [IDX_W-1:0]   push_idx;
    logic [IDX_W-1:0]   pop_idx;
    logic [WIDTH-1:0]   q_base;
    logic [WIDTH-1:0]   q_wr;
    logic [WIDTH-1:0]   q_nxt;
    logic [LEVEL_W-1:0] level_nxt;
    logic               err_nxt;

    always_comb begin
        push_op   = bus.push & ~bus.pop;
        pop_op    = bus.pop & ~bus.push;
        do_push   = push_op & ~full_r;
        do_pop    = pop_op & ~empty_r;
        stack_err = (bus.push & bus.pop) | (push_op & full_r) | (pop_op & empty_r);

        push_idx  = IDX_W'(level_r);
        pop_idx   = IDX_W'(level_r - LEVEL_W'(1));

        // Sticky bits are cleared first so a same-cycle write of 1 still sets them.
        q_base    = bus.clear_sticky ? (q_r & ~STICKY_BITS) : q_r;
        q_wr      = (bus.d & ~STICKY_BITS) | ((q_base | bus.d) & STICKY_BITS);

        q_nxt     = q_base;
        if (do_pop) begin
            q_nxt = stack[pop_idx];
        end else if (bus.write_enable) begin
            q_nxt = (q_base & ~bus.wmask) | (q_wr & bus.wmask);
        end

        level_nxt = level_r;
        if (do_push) begin
            level_nxt = level_r + LEVEL_W'(1);
        end else if (do_pop) begin
            level_nxt = level_r - LEVEL_W'(1);
        end

        err_nxt   = (err_r & ~bus.clear_sticky) | stack_err;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_r     <= '0;
            level_r <= '0;
            full_r  <= 1'b0;
            empty_r <= 1'b1;
            err_r   <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                stack[i] <= '0;
            end
        end else begin
            q_r     <= q_nxt;
            level_r <= level_nxt;
            full_r  <= (level_nxt == LEVEL_W'(DEPTH));
            empty_r <= (level_nxt == '0);
            err_r   <= err_nxt;
            if (do_push) begin
                stack[push_idx] <= q_r;
            end
        end
    end

    assign bus.q     = q_r;
    assign bus.level = level_r;
    assign bus.full  = full_r;
    assign bus.empty = empty_r;
    assign bus.err   = err_r;
endmodule

// File: tb/tb_flags_context_register.sv
// Directed vector bench for flags_context_register (WIDTH=4, DEPTH=2, STICKY_MASK=1000).
// Expected q[3] after sticky writes follows whether FLAGS_STICKY_EN is defined.
module tb_flags_context_register;
`ifdef FLAGS_STICKY_EN
    localparam bit STICKY = 1'b1;
`else
    localparam bit STICKY = 1'b0;
`endif

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_bad;

    flags_context_register_if #(.WIDTH(4), .DEPTH(2)) bus ();

    flags_context_register #(
        .WIDTH(4),
        .DEPTH(2),
        .STICKY_MASK(4'b1000)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        string      name;
        logic       we;
        logic [3:0] wmask;
        logic [3:0] d;
        logic       push;
        logic       pop;
        logic       clr;
        logic [3:0] eq;
        logic [1:0] el;
        logic       efull;
        logic       eempty;
        logic       eerr;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(string name, logic we, logic [3:0] wmask, logic [3:0] d,
                                logic push, logic pop, logic clr, logic [3:0] eq,
                                logic [1:0] el, logic efull, logic eempty, logic eerr);
        vec_t v;
        v.name = name; v.we = we; v.wmask = wmask; v.d = d;
        v.push = push; v.pop = pop; v.clr = clr;
        v.eq = eq; v.el = el; v.efull = efull; v.eempty = eempty; v.eerr = eerr;
        return v;
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_all(string name, logic [3:0] eq, logic [1:0] el,
                             logic efull, logic eempty, logic eerr);
        check({name, ".q"},     32'(bus.q),     32'(eq));
        check({name, ".level"}, 32'(bus.level), 32'(el));
        check({name, ".full"},  32'(bus.full),  32'(efull));
        check({name, ".empty"}, 32'(bus.empty), 32'(eempty));
        check({name, ".err"},   32'(bus.err),   32'(eerr));
    endtask

    task automatic drive(logic we, logic [3:0] wmask, logic [3:0] d,
                         logic push, logic pop, logic clr);
        bus.write_enable = we;
        bus.wmask        = wmask;
        bus.d            = d;
        bus.push         = push;
        bus.pop          = pop;
        bus.clear_sticky = clr;
    endtask

    task automatic step(logic we, logic [3:0] wmask, logic [3:0] d,
                        logic push, logic pop, logic clr);
        @(negedge clk);
        drive(we, wmask, d, push, pop, clr);
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        drive(1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;

        //                 name         we m     d      pu po cl  q      lv full emp err
        vecs.push_back(mk("wr_0100",    1, 4'hF, 4'h4,  0, 0, 0,  4'h4,  0, 0, 1, 0));
        vecs.push_back(mk("wr_mask",    1, 4'h1, 4'h3,  0, 0, 0,  4'h5,  0, 0, 1, 0));
        vecs.push_back(mk("push1",      0, 4'h0, 4'h0,  1, 0, 0,  4'h5,  1, 0, 0, 0));
        vecs.push_back(mk("wr_1010",    1, 4'hF, 4'hA,  0, 0, 0,  4'hA,  1, 0, 0, 0));
        vecs.push_back(mk("push2",      0, 4'h0, 4'h0,  1, 0, 0,  4'hA,  2, 1, 0, 0));
        vecs.push_back(mk("wr_1111",    1, 4'hF, 4'hF,  0, 0, 0,  4'hF,  2, 1, 0, 0));
        vecs.push_back(mk("pop1",       0, 4'h0, 4'h0,  0, 1, 0,  4'hA,  1, 0, 0, 0));
        vecs.push_back(mk("pop2",       0, 4'h0, 4'h0,  0, 1, 0,  4'h5,  0, 0, 1, 0));
        vecs.push_back(mk("refill1",    0, 4'h0, 4'h0,  1, 0, 0,  4'h5,  1, 0, 0, 0));
        vecs.push_back(mk("refill2",    0, 4'h0, 4'h0,  1, 0, 0,  4'h5,  2, 1, 0, 0));
        vecs.push_back(mk("push_full",  0, 4'h0, 4'h0,  1, 0, 0,  4'h5,  2, 1, 0, 1));
        vecs.push_back(mk("pushfull_wr",1, 4'hF, 4'h6,  1, 0, 0,  4'h6,  2, 1, 0, 1));
        vecs.push_back(mk("drain1",     0, 4'h0, 4'h0,  0, 1, 0,  4'h5,  1, 0, 0, 1));
        vecs.push_back(mk("drain2",     0, 4'h0, 4'h0,  0, 1, 0,  4'h5,  0, 0, 1, 1));
        vecs.push_back(mk("pop_empty",  0, 4'h0, 4'h0,  0, 1, 0,  4'h5,  0, 0, 1, 1));
        vecs.push_back(mk("popempty_wr",1, 4'h3, 4'hE,  0, 1, 0,  4'h6,  0, 0, 1, 1));
        vecs.push_back(mk("clear_err",  0, 4'h0, 4'h0,  0, 0, 1,  4'h6,  0, 0, 1, 0));
        vecs.push_back(mk("clr_push",   0, 4'h0, 4'h0,  1, 0, 1,  4'h6,  1, 0, 0, 0));
        vecs.push_back(mk("pushpop_wr", 1, 4'hF, 4'h3,  1, 1, 0,  4'h3,  1, 0, 0, 1));
        vecs.push_back(mk("pop_wins",   1, 4'hF, 4'hF,  0, 1, 0,  4'h6,  0, 0, 1, 1));
        vecs.push_back(mk("clr_and_err",0, 4'h0, 4'h0,  0, 1, 1,  4'h6,  0, 0, 1, 1));
        vecs.push_back(mk("clear_err2", 0, 4'h0, 4'h0,  0, 0, 1,  4'h6,  0, 0, 1, 0));
        vecs.push_back(mk("wr_nomask",  1, 4'h0, 4'hF,  0, 0, 0,  4'h6,  0, 0, 1, 0));
        vecs.push_back(mk("stk_set",    1, 4'hF, 4'h8,  0, 0, 0,  4'h8,  0, 0, 1, 0));
        vecs.push_back(mk("stk_wr0",    1, 4'hF, 4'h0,  0, 0, 0,  STICKY ? 4'h8 : 4'h0, 0, 0, 1, 0));
        vecs.push_back(mk("stk_clear",  0, 4'h0, 4'h0,  0, 0, 1,  4'h0,  0, 0, 1, 0));
        vecs.push_back(mk("stk_clr_wr", 1, 4'hF, 4'h8,  0, 0, 1,  4'h8,  0, 0, 1, 0));

        // Asynchronous reset at start-up, checked before any clock edge
        #1 rst = 1'b1;
        #1;
        check_all("reset", 4'h0, 2'd0, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        rst = 1'b0;

        foreach (vecs[i]) begin
            step(vecs[i].we, vecs[i].wmask, vecs[i].d, vecs[i].push, vecs[i].pop, vecs[i].clr);
            check_all(vecs[i].name, vecs[i].eq, vecs[i].el, vecs[i].efull, vecs[i].eempty, vecs[i].eerr);
        end

        // Mid-cycle reset with a full stack and err set
        step(1'b0, 4'h0, 4'h0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 4'h0, 4'h0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 4'h0, 4'h0, 1'b1, 1'b0, 1'b0);
        check_all("pre_rst", 4'h8, 2'd2, 1'b1, 1'b0, 1'b1);
        @(negedge clk);
        drive(1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0);
        #2 rst = 1'b1;
        #1;
        check_all("async_rst", 4'h0, 2'd0, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        rst = 1'b0;

        // Stack contents were discarded: pop finds nothing to restore
        step(1'b0, 4'h0, 4'h0, 1'b0, 1'b1, 1'b0);
        check_all("post_rst_pop", 4'h0, 2'd0, 1'b0, 1'b1, 1'b1);
        step(1'b1, 4'hF, 4'h3, 1'b0, 1'b0, 1'b0);
        check_all("post_rst_wr", 4'h3, 2'd0, 1'b0, 1'b1, 1'b1);

        @(negedge clk);
        drive(1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
